pet2001_clkgen: RTL

- Clock-enable generator directly upstream of pet2001hw; the only timing source for the video, VRAM arbitration and I/O.
- Divides the single system clk into the 8 MHz positive/negative phase strobes (ce_8mp/ce_8mn), the 1 MHz system strobe (ce_1m) and a CPU strobe (ce_cpu).
- Applies turbo (clk_speed) and freeze (clk_stop) only to the CPU strobe, at 1 MHz cycle boundaries, so video timing never breaks.

---
 rtl/pet2001_clkgen.sv | 89 ++++++++
 1 files changed

// File: rtl/pet2001_clkgen.sv
// Clock-enable generator: 8 MHz phase strobes, 1 MHz system strobe and a turbo/freeze-able CPU strobe.
// Optional cpu_cycles counter enabled by defining PET_CLKGEN_CYCLE_COUNT_EN.
module pet2001_clkgen #(
  parameter int CLK_PER_8M = 7,
  parameter int NEG_PHASE  = 4
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        clk_speed_i,
  input  logic        clk_stop_i,
  output logic        ce_8mp_o,
  output logic        ce_8mn_o,
  output logic        ce_1m_o,
  output logic        ce_cpu_o,
`ifdef PET_CLKGEN_CYCLE_COUNT_EN
  output logic        stopped_o,
  output logic [31:0] cpu_cycles_o
`else
  output logic        stopped_o
`endif
);

  localparam logic [3:0] PH_LAST = 4'(CLK_PER_8M - 1);
  localparam logic [3:0] PH_NEG  = 4'(NEG_PHASE);

  logic [3:0] ph_q, ph_d;
  logic [2:0] sub_q, sub_d;
  logic       speed_q, stop_q;
  logic       ce_8mp_q, ce_8mn_q, ce_1m_q, ce_cpu_q;
  logic       ce_8mp_d, ce_8mn_d, ce_1m_d, ce_cpu_d;
  logic       wrap;

  assign wrap = (ph_q == PH_LAST);

  // Strobes decode the current count and are registered, so each lands one clk later.
  always_comb begin
    ph_d     = wrap ? 4'd0 : ph_q + 4'd1;
    sub_d    = wrap ? sub_q + 3'd1 : sub_q;
    ce_8mp_d = (ph_q == 4'd0);
    ce_8mn_d = (ph_q == PH_NEG);
    ce_1m_d  = wrap && (sub_q == 3'd7);
    ce_cpu_d = !stop_q && (speed_q ? wrap : ce_1m_d);
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      ph_q     <= 4'd0;
      sub_q    <= 3'd0;
      speed_q  <= 1'b0;
      stop_q   <= 1'b0;
      ce_8mp_q <= 1'b0;
      ce_8mn_q <= 1'b0;
      ce_1m_q  <= 1'b0;
      ce_cpu_q <= 1'b0;
    end else begin
      ph_q     <= ph_d;
      sub_q    <= sub_d;
      ce_8mp_q <= ce_8mp_d;
      ce_8mn_q <= ce_8mn_d;
      ce_1m_q  <= ce_1m_d;
      ce_cpu_q <= ce_cpu_d;
      // Mode changes only at a 1 MHz boundary so CPU cycles are never cut short.
      if (ce_1m_q) begin
        speed_q <= clk_speed_i;
        stop_q  <= clk_stop_i;
      end
    end
  end

  assign ce_8mp_o  = ce_8mp_q;
  assign ce_8mn_o  = ce_8mn_q;
  assign ce_1m_o   = ce_1m_q;
  assign ce_cpu_o  = ce_cpu_q;
  assign stopped_o = stop_q;

`ifdef PET_CLKGEN_CYCLE_COUNT_EN
  logic [31:0] cyc_q, cyc_d;

  assign cyc_d = cyc_q + 32'(ce_cpu_q);

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) cyc_q <= 32'd0;
    else         cyc_q <= cyc_d;
  end

  assign cpu_cycles_o = cyc_q;
`endif

endmodule
